pipeline_hazard_controller: RTL

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/pipeline_hazard_controller_if.sv | 43 ++++
 rtl/pipeline_hazard_controller_sat_counter.sv | 20 ++
 rtl/pipeline_hazard_controller.sv | 125 ++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types, defaults and hazard-decode helper for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  localparam int unsigned MDU_TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned REG_W           = 5;

  // Load-use: EX holds a load to a non-zero register that the ID instruction actually reads.
  function automatic logic load_use(
    input logic             memread,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs1,
    input logic             use1,
    input logic [REG_W-1:0] rs2,
    input logic             use2
  );
    return memread && (rd != '0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the controller (slave).
interface pipeline_hazard_controller_if
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic [REG_W-1:0] rs1_id;
  logic [REG_W-1:0] rs2_id;
  logic             uses_rs1_id;
  logic             uses_rs2_id;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rd;
  logic             branch_taken_ex;
  logic             mdu_req_ex;
  logic             mdu_done;

  logic             pc_write_en;
  logic             ifid_write_en;
  logic             idex_write_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_bubble;
  logic             mdu_start;
  logic             mdu_timeout_err;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output rs1_id, rs2_id, uses_rs1_id, uses_rs2_id, idex_memread, idex_rd,
           branch_taken_ex, mdu_req_ex, mdu_done,
    input  pc_write_en, ifid_write_en, idex_write_en, ifid_flush, idex_flush,
           exmem_bubble, mdu_start, mdu_timeout_err, stall_count, flush_count
  );

  modport slave (
    input  rs1_id, rs2_id, uses_rs1_id, uses_rs2_id, idex_memread, idex_rd,
           branch_taken_ex, mdu_req_ex, mdu_done,
    output pc_write_en, ifid_write_en, idex_write_en, ifid_flush, idex_flush,
           exmem_bubble, mdu_start, mdu_timeout_err, stall_count, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes, multi-cycle MDU waits with timeout.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = MDU_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input logic                         clk,
  input logic                         rst,
  pipeline_hazard_controller_if.slave hif
);

  localparam int unsigned WAIT_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;

  state_t           state;
  logic [WAIT_W-1:0] wait_cnt;
  logic             err_q;
  logic             lu;

  logic             pc_we;
  logic             ifid_we;
  logic             idex_we;
  logic             ifid_fl;
  logic             idex_fl;
  logic             bubble;
  logic             start;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign lu = load_use(hif.idex_memread, hif.idex_rd, hif.rs1_id, hif.uses_rs1_id,
                       hif.rs2_id, hif.uses_rs2_id);

  // Pipeline controls decoded in the same cycle from state and hazard inputs; reset forces defaults.
  always_comb begin
    pc_we   = 1'b1;
    ifid_we = 1'b1;
    idex_we = 1'b1;
    ifid_fl = 1'b0;
    idex_fl = 1'b0;
    bubble  = 1'b0;
    start   = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (hif.branch_taken_ex) begin
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
          end else if (hif.mdu_req_ex) begin
            start = 1'b1;
          end else if (lu) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_fl = 1'b1;
          end
        end
        MDU_WAIT: begin
          // The done cycle already releases the pipeline so the MDU result advances.
          if (!hif.mdu_done) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_we = 1'b0;
            bubble  = 1'b1;
          end
        end
      endcase
    end
  end

  // FSM, wait-cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!hif.branch_taken_ex && hif.mdu_req_ex) begin
            state    <= MDU_WAIT;
            wait_cnt <= '0;
          end
        end
        MDU_WAIT: begin
          if (hif.mdu_done) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MDU_TIMEOUT - 1)) begin
            err_q    <= 1'b1;
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_we),
    .count (stall_q)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ifid_fl),
    .count (flush_q)
  );

  assign hif.pc_write_en     = pc_we;
  assign hif.ifid_write_en   = ifid_we;
  assign hif.idex_write_en   = idex_we;
  assign hif.ifid_flush      = ifid_fl;
  assign hif.idex_flush      = idex_fl;
  assign hif.exmem_bubble    = bubble;
  assign hif.mdu_start       = start;
  assign hif.mdu_timeout_err = err_q;
  assign hif.stall_count     = stall_q;
  assign hif.flush_count     = flush_q;

endmodule
